// File: rtl/itch_pkg.sv
// itch_pkg: shared ITCH type codes, dispatcher states and header field layout
package itch_pkg;
   localparam logic [7:0] CHAR_D = 8'h44;
   localparam logic [7:0] CHAR_E = 8'h45;
   localparam logic [7:0] CHAR_X = 8'h58;
   localparam logic [7:0] CHAR_C = 8'h43;
   localparam int TYPE_LSB = 0;
   localparam int LEN_LSB = 16;
   typedef enum logic [2:0] {
      TYPE_D = 3'd0,
      TYPE_E = 3'd1,
      TYPE_X = 3'd2,
      TYPE_C = 3'd3
   } itch_type_e;
   typedef enum logic [2:0] {IDLE, ARM, FORWARD, DRAIN, WAIT_DONE, GAP} disp_state_e;
   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction
endpackage

// File: rtl/itch_type_decode.sv
// itch_type_decode: maps an ITCH type character to {supported, parser type code}
module itch_type_decode
   import itch_pkg::*;
(
   input  logic [7:0] type_char,
   output logic       supported,
   output itch_type_e code
);
   always_comb begin
      supported = type_char inside {CHAR_D, CHAR_E, CHAR_X, CHAR_C};
      code = (type_char == CHAR_E) ? TYPE_E :
             (type_char == CHAR_X) ? TYPE_X :
             (type_char == CHAR_C) ? TYPE_C : TYPE_D;
   end
endmodule

// File: rtl/itch_msg_dispatcher.sv
// itch_msg_dispatcher: routes framed ITCH messages to the cancel/delete/execute parser, drains the rest
module itch_msg_dispatcher
   import itch_pkg::*;
#(
   parameter int DATA_WIDTH = 31,
   parameter int LEN_WIDTH  = 16,
   parameter int TIMEOUT    = 64,
   parameter int GAP_CYCLES = 1
) (
   input  logic                  clk_in,
   input  logic                  reset_in,
   input  logic [DATA_WIDTH:0]   s_data_in,
   input  logic                  s_valid_in,
   input  logic                  s_sop_in,
   output logic                  s_ready_out,
   output logic                  enable_out,
   output logic [2:0]            mess_type_out,
   output logic                  valid_out,
   output logic [DATA_WIDTH:0]   data_out,
   input  logic                  parser_ready_in,
   output logic                  msg_done_out,
   output logic                  err_out,
   output logic [15:0]           drop_count_out
);
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam int GW = $clog2(GAP_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);
   localparam logic [LEN_WIDTH-2:0] CNT_ONE = (LEN_WIDTH-1)'(1);
   disp_state_e          state;
   logic [LEN_WIDTH-1:0] len;
   logic [LEN_WIDTH-2:0] n, cnt;
   logic [TW-1:0]        tmo;
   logic [GW-1:0]        gap;
   logic                 supported, sop_hit, accept;
   itch_type_e           code;
   itch_type_decode u_dec (
      .type_char(s_data_in[TYPE_LSB +: 8]),
      .supported(supported),
      .code(code)
   );
   // (L+3)>>2 without carrying the two discarded low sum bits
   always_comb begin
      len = s_data_in[LEN_LSB +: LEN_WIDTH];
      n = {1'b0, len[LEN_WIDTH-1:2]} + (LEN_WIDTH-1)'(|len[1:0]);
      sop_hit = s_sop_in && s_valid_in;
      s_ready_out = (state == IDLE) || ((state == FORWARD || state == DRAIN) && !sop_hit);
      accept = s_valid_in && s_ready_out;
   end
   always_ff @(posedge clk_in) begin
      if (reset_in) begin
         state <= IDLE;
         enable_out <= 1'b0;
         mess_type_out <= '0;
         valid_out <= 1'b0;
         data_out <= '0;
         msg_done_out <= 1'b0;
         err_out <= 1'b0;
         drop_count_out <= '0;
         cnt <= '0;
         tmo <= '0;
         gap <= '0;
      end else begin
         valid_out <= 1'b0;
         msg_done_out <= 1'b0;
         err_out <= 1'b0;
         case (state)
            IDLE: if (accept) begin
               if (!s_sop_in || n == '0) begin
                  err_out <= 1'b1;
                  if (s_sop_in && !supported) drop_count_out <= sat_inc(drop_count_out);
               end else begin
                  cnt <= n;
                  enable_out <= supported;
                  state <= supported ? ARM : DRAIN;
                  if (supported) mess_type_out <= code;
               end
            end
            ARM: state <= FORWARD;
            FORWARD: if (sop_hit) begin
               err_out <= 1'b1;
               enable_out <= 1'b0;
               gap <= '0;
               state <= GAP;
            end else if (accept) begin
               data_out <= s_data_in;
               valid_out <= 1'b1;
               cnt <= cnt - 1'b1;
               if (cnt == CNT_ONE) begin
                  tmo <= '0;
                  state <= WAIT_DONE;
               end
            end
            // a sop mid-drain still retires the dropped message
            DRAIN: if (sop_hit || accept) begin
               cnt <= cnt - 1'b1;
               err_out <= sop_hit;
               if (sop_hit || cnt == CNT_ONE) begin
                  drop_count_out <= sat_inc(drop_count_out);
                  state <= IDLE;
               end
            end
            WAIT_DONE: if (parser_ready_in || tmo == TMO_LAST) begin
               msg_done_out <= parser_ready_in;
               err_out <= !parser_ready_in;
               enable_out <= 1'b0;
               gap <= '0;
               state <= GAP;
            end else begin
               tmo <= tmo + 1'b1;
            end
            GAP: if (gap == GAP_LAST) state <= IDLE;
               else gap <= gap + 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_itch_msg_dispatcher.sv
// tb_itch_msg_dispatcher: scoreboard bench for itch_msg_dispatcher
module tb_itch_msg_dispatcher;
   localparam int K_ENA = 0, K_DATA = 1, K_DONE = 2, K_ERR = 3;
   typedef struct {
      int          kind;
      logic [31:0] val;
   } evt_t;
   logic        clk_in = 1'b0, reset_in = 1'b1;
   logic [31:0] s_data_in = '0;
   logic        s_valid_in = 1'b0, s_sop_in = 1'b0, parser_ready_in = 1'b0;
   logic        s_ready_out, enable_out, valid_out, msg_done_out, err_out;
   logic [2:0]  mess_type_out;
   logic [31:0] data_out;
   logic [15:0] drop_count_out;
   int compared = 0, mismatched = 0, cyc = 0;
   int ena_cyc = 0, fall_cyc = 0, done_cyc = 0, err_cyc = 0, lv_cyc = 0, n_done = 0, n_err = 0;
   logic ena_q = 1'b0;
   int vcyc[$];
   evt_t sb[$];

   itch_msg_dispatcher dut (
      .clk_in(clk_in), .reset_in(reset_in),
      .s_data_in(s_data_in), .s_valid_in(s_valid_in), .s_sop_in(s_sop_in), .s_ready_out(s_ready_out),
      .enable_out(enable_out), .mess_type_out(mess_type_out), .valid_out(valid_out), .data_out(data_out),
      .parser_ready_in(parser_ready_in), .msg_done_out(msg_done_out), .err_out(err_out),
      .drop_count_out(drop_count_out)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic expect_evt(input int kind, input logic [31:0] val, input string name);
      evt_t e;
      compared++;
      if (sb.size() == 0) begin
         mismatched++;
         $display("FAIL %s: unexpected event value %0h, nothing expected", name, val);
      end else begin
         e = sb.pop_front();
         if (e.kind != kind || e.val !== val) begin
            mismatched++;
            $display("FAIL %s: got kind %0d value %0h, required kind %0d value %0h", name, kind, val, e.kind, e.val);
         end
      end
   endtask

   function automatic void push(input int kind, input logic [31:0] val);
      evt_t e;
      e.kind = kind;
      e.val = val;
      sb.push_back(e);
   endfunction

   function automatic logic [31:0] hdr(input logic [7:0] ch, input logic [15:0] l);
      return {l, 8'h00, ch};
   endfunction

   // monitor: pops the scoreboard whenever the DUT presents something
   always @(negedge clk_in) begin
      if (enable_out && !ena_q) begin
         ena_cyc = cyc;
         expect_evt(K_ENA, {29'd0, mess_type_out}, "enable_rise");
      end
      if (!enable_out && ena_q) fall_cyc = cyc;
      ena_q = enable_out;
      if (valid_out) begin
         vcyc.push_back(cyc);
         lv_cyc = cyc;
         expect_evt(K_DATA, data_out, "payload");
      end
      if (msg_done_out) begin
         done_cyc = cyc;
         n_done++;
         expect_evt(K_DONE, 32'd0, "msg_done");
      end
      if (err_out) begin
         err_cyc = cyc;
         n_err++;
         expect_evt(K_ERR, 32'd0, "err");
      end
   end

   task automatic send(input logic [31:0] d, input logic sop, output int first, output int acc);
      bit ok = 1'b0;
      first = -1;
      acc = -1;
      s_data_in = d;
      s_sop_in = sop;
      s_valid_in = 1'b1;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge clk_in);
         if (first < 0) first = cyc;
         ok = s_ready_out;
         acc = cyc;
         @(posedge clk_in);
         #1;
      end
      s_valid_in = 1'b0;
      s_sop_in = 1'b0;
      if (!ok) begin
         compared++;
         mismatched++;
         $display("FAIL send: word %0h never accepted", d);
      end
   endtask

   task automatic wait_done(input string name);
      int s = n_done;
      for (int t = 0; t < 200 && n_done == s; t++) @(posedge clk_in);
      #1;
      chk(name, n_done - s, 1);
   endtask

   task automatic wait_err(input string name);
      int s = n_err;
      for (int t = 0; t < 200 && n_err == s; t++) @(posedge clk_in);
      #1;
      chk(name, n_err - s, 1);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int f, a, t0, last;
      repeat (2) @(posedge clk_in);
      #1;
      chk("rst_enable", enable_out, 0);
      chk("rst_valid", valid_out, 0);
      chk("rst_pulses", {err_out, msg_done_out}, 0);
      chk("rst_type_data", {mess_type_out, data_out}, 0);
      chk("rst_drop", drop_count_out, 0);
      chk("rst_ready", s_ready_out, 1);
      reset_in = 1'b0;
      // 'X' N=5, ready three cycles after last word
      push(K_ENA, 2);
      send(hdr(8'h58, 16'd19), 1'b1, f, t0);
      for (int k = 1; k <= 5; k++) begin
         push(K_DATA, 32'h11111111 * k);
         send(32'h11111111 * k, 1'b0, f, last);
      end
      push(K_DONE, 0);
      repeat (2) @(posedge clk_in);
      #1;
      parser_ready_in = 1'b1;
      @(posedge clk_in);
      #1;
      chk("gap_enable", enable_out, 0);
      chk("gap_ready", s_ready_out, 0);
      @(posedge clk_in);
      #1;
      chk("idle_ready", s_ready_out, 1);
      chk("ena_latency", ena_cyc - t0, 1);
      chk("first_valid", vcyc[0] - t0, 3);
      chk("done_time", done_cyc - last, 4);
      chk("fall_time", fall_cyc - last, 4);
      // unsupported 'A' N=9 drained, then 'D'
      parser_ready_in = 1'b0;
      send(hdr(8'h41, 16'd35), 1'b1, f, a);
      for (int k = 0; k < 9; k++) send(32'hA0000000 + k, 1'b0, f, a);
      chk("drop_after_A", drop_count_out, 1);
      chk("ready_after_A", s_ready_out, 1);
      parser_ready_in = 1'b1;
      push(K_ENA, 0);
      send(hdr(8'h44, 16'd4), 1'b1, f, a);
      push(K_DATA, 32'hD0D0D0D0);
      send(32'hD0D0D0D0, 1'b0, f, a);
      push(K_DONE, 0);
      wait_done("done_D");
      // 'E' N=4 interrupted by a new sop after 2 words
      push(K_ENA, 1);
      send(hdr(8'h45, 16'd16), 1'b1, f, a);
      push(K_DATA, 32'hE1E1E1E1);
      send(32'hE1E1E1E1, 1'b0, f, a);
      push(K_DATA, 32'hE2E2E2E2);
      send(32'hE2E2E2E2, 1'b0, f, a);
      push(K_ERR, 0);
      push(K_ENA, 2);
      send(hdr(8'h58, 16'd8), 1'b1, f, a);
      chk("resop_accept", a - f, 2);
      chk("abort_err_time", err_cyc - f, 1);
      chk("abort_fall_time", fall_cyc - f, 1);
      push(K_DATA, 32'h5A5A0001);
      send(32'h5A5A0001, 1'b0, f, a);
      push(K_DATA, 32'h5A5A0002);
      send(32'h5A5A0002, 1'b0, f, a);
      push(K_DONE, 0);
      wait_done("done_resop");
      // 'D' N=2 with parser never ready
      parser_ready_in = 1'b0;
      push(K_ENA, 0);
      send(hdr(8'h44, 16'd8), 1'b1, f, a);
      push(K_DATA, 32'h0D000001);
      send(32'h0D000001, 1'b0, f, a);
      push(K_DATA, 32'h0D000002);
      send(32'h0D000002, 1'b0, f, a);
      push(K_ERR, 0);
      wait_err("timeout_seen");
      chk("timeout_time", err_cyc - lv_cyc, 64);
      chk("timeout_fall", fall_cyc, err_cyc);
      // 'C' N=8 with valid toggling
      parser_ready_in = 1'b1;
      vcyc.delete();
      push(K_ENA, 3);
      send(hdr(8'h43, 16'd32), 1'b1, f, a);
      for (int k = 0; k < 8; k++) begin
         push(K_DATA, 32'hC0000000 | k);
         send(32'hC0000000 | k, 1'b0, f, a);
         @(posedge clk_in);
         #1;
      end
      push(K_DONE, 0);
      wait_done("done_C");
      chk("c_words", vcyc.size(), 8);
      for (int k = 0; k < 7; k++) chk("c_valid_gap", vcyc[k+1] - vcyc[k], 2);
      // reset mid-FORWARD
      push(K_ENA, 2);
      send(hdr(8'h58, 16'd12), 1'b1, f, a);
      push(K_DATA, 32'h66666666);
      send(32'h66666666, 1'b0, f, a);
      reset_in = 1'b1;
      @(posedge clk_in);
      #1;
      reset_in = 1'b0;
      chk("mrst_enable", enable_out, 0);
      chk("mrst_valid", valid_out, 0);
      chk("mrst_type", mess_type_out, 0);
      chk("mrst_ready", s_ready_out, 1);
      chk("mrst_drop", drop_count_out, 0);
      push(K_ENA, 2);
      send(hdr(8'h58, 16'd4), 1'b1, f, a);
      push(K_DATA, 32'h77777777);
      send(32'h77777777, 1'b0, f, a);
      push(K_DONE, 0);
      wait_done("done_after_rst");
      // zero-length headers and a stray non-sop word
      push(K_ERR, 0);
      send(hdr(8'h44, 16'd0), 1'b1, f, a);
      push(K_ERR, 0);
      send(hdr(8'h5A, 16'd0), 1'b1, f, a);
      push(K_ERR, 0);
      send(32'h12345678, 1'b0, f, a);
      @(posedge clk_in);
      #1;
      chk("drop_zero_len", drop_count_out, 1);
      // maximum length: L=0xFFFF gives 16384 words
      send(hdr(8'h5A, 16'hFFFF), 1'b1, f, a);
      for (int k = 0; k < 16383; k++) send(k, 1'b0, f, a);
      chk("drop_before_last", drop_count_out, 1);
      send(32'hFFFF0000, 1'b0, f, a);
      chk("drop_max_len", drop_count_out, 2);
      repeat (5) @(posedge clk_in);
      #1;
      chk("sb_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule

// File: doc/itch_msg_dispatcher.md
Name: itch_msg_dispatcher

Overview:
- Sits directly upstream of the order-cancel/delete/execute parser.
- Takes the framed 32-bit ITCH word stream, decodes the message-type header word and routes supported messages to the parser.
- Drives the parser's enable/mess_type/valid/data inputs and waits on its ready before starting the next message.
- Drains unsupported message types silently and counts them.

Parameters:
- DATA_WIDTH, 31: MSB index of the data bus (bus is DATA_WIDTH+1 bits).
- LEN_WIDTH, 16: width of the payload byte-count field in the header word.
- TIMEOUT, 64: maximum cycles to wait for parser ready after the last payload word.
- GAP_CYCLES, 1: cycles enable_out is held low between messages; must be at least 1.

Ports:
- clk_in  in  1  clock
- reset_in  in  1  synchronous, active-high reset
- s_data_in  in  DATA_WIDTH+1  stream word
- s_valid_in  in  1  stream word valid
- s_sop_in  in  1  word is a message header
- s_ready_out  out  1  stream word accepted when s_valid_in && s_ready_out
- enable_out  out  1  parser enable; the rising edge starts a message
- mess_type_out  out  3  parser type code
- valid_out  out  1  payload word valid to parser
- data_out  out  DATA_WIDTH+1  payload word to parser
- parser_ready_in  in  1  parser result ready
- msg_done_out  out  1  one-cycle pulse when a parser result is taken
- err_out  out  1  one-cycle protocol/timeout error pulse
- drop_count_out  out  16  count of drained unsupported messages; saturates at 16'hFFFF

Behaviour:
- Header word format:
  - [7:0] = ASCII type.
  - [15:8] = reserved, ignored.
  - [15+LEN_WIDTH:16] = payload byte count L.
  - Payload word count N = (L+3)>>2.
- Type map:
  - 'D' 0x44 -> 0
  - 'E' 0x45 -> 1
  - 'X' 0x58 -> 2
  - 'C' 0x43 -> 3
  - all other types are unsupported.
- Reset values: all outputs 0, state IDLE, counters 0.
- States: IDLE, ARM, FORWARD, DRAIN, WAIT_DONE, GAP.
- s_ready_out (combinational from state):
  - 1 in IDLE, FORWARD, DRAIN.
  - 0 in ARM, WAIT_DONE, GAP.
  - In FORWARD/DRAIN it is also 0 while s_sop_in && s_valid_in.
- IDLE:
  - Accepted sop word of a supported type with N>0: latch type and N; go to ARM.
  - Unsupported type with N>0: go to DRAIN.
  - Any type with N==0: err_out pulse; if unsupported, also increment drop_count_out; stay IDLE.
  - Accepted non-sop word: discarded, err_out pulse.
- ARM (1 cycle):
  - enable_out=1, mess_type_out valid and held stable until GAP.
  - The parser sees the enable rising edge this cycle; no payload is presented.
  - Go to FORWARD.
- FORWARD:
  - Each accepted word is registered to data_out with valid_out=1 on the next cycle (1-cycle latency); otherwise valid_out=0.
  - A word counter counts accepted words; after the Nth word go to WAIT_DONE.
  - Worst-case timing: sop accepted at cycle T -> enable_out rises at T+1 -> first valid_out no earlier than T+3.
- DRAIN:
  - Accept and discard N words; no outputs toggle.
  - After the Nth word: drop_count_out++ (saturating); go to IDLE.
- WAIT_DONE:
  - enable_out stays 1.
  - First cycle with parser_ready_in=1: msg_done_out pulse; go to GAP.
  - If TIMEOUT cycles elapse without ready: err_out pulse; go to GAP.
- GAP:
  - enable_out=0 for GAP_CYCLES cycles, then go to IDLE.
- sop arriving mid-message (FORWARD/DRAIN):
  - err_out pulse; the sop word is not accepted.
  - FORWARD aborts to GAP. DRAIN returns to IDLE and still increments drop_count_out.
  - The upstream re-presents the sop word, which is accepted once back in IDLE.
- s_valid_in low: counters hold, no timeout accrues in FORWARD.
- reset_in mid-message: immediate return to IDLE; enable_out and valid_out drop on the next edge.
- Width rules:
  - The N counter is LEN_WIDTH-1 bits wide.
  - The (L+3) sum is computed in LEN_WIDTH+1 bits, so L=0xFFFF gives N=16384.

Decomposition:
- Package itch_pkg holds:
  - ITCH type-char localparams ('D','E','X','C').
  - The 3-bit type-code enum shared with the parser.
  - The dispatcher state enum.
  - Header field offsets.
- One natural sub-module: itch_type_decode (combinational char -> {supported, code}). It is reused by future add/replace routers.

Test Plan:
- Header 'X' (0x58) with L=19 (N=5), then 5 payload words 0x11111111..0x55555555, parser_ready_in raised 3 cycles after the last word:
  - enable_out rises 1 cycle after the sop is accepted; mess_type_out=2.
  - Five valid_out words in order.
  - msg_done_out pulses once; enable_out low for 1 cycle; s_ready_out then returns to 1.
- Header 'A' (0x41) with L=35 (N=9), 9 words:
  - enable_out stays 0; drop_count_out=1; next 'D' message routed with mess_type_out=0.
- 'E' header with N=4, sop arriving after 2 payload words:
  - err_out pulse; the sop word is not accepted; enable_out low for GAP_CYCLES.
  - The new message is accepted and routed normally.
- 'D' message forwarded, parser_ready_in never asserted:
  - err_out pulses exactly TIMEOUT=64 cycles after the last word; enable_out falls; next message accepted.
- s_valid_in toggled 0/1 every cycle during a 'C' N=8 message:
  - All 8 words delivered in order; no timeout; valid_out gaps mirror the input gaps.
- reset_in asserted for 1 cycle mid-FORWARD:
  - Next cycle all outputs 0, s_ready_out=1.
  - drop_count_out=0 after reset; a following 'X' message is routed correctly.
